// File: rtl/snax_gemm_pkg.sv
// Shared types and default widths for the SNAX GEMM tile sequencer.
// The descriptor struct packs exactly as {bases, dims, strides} on the config port.
package snax_gemm_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned DIM_WIDTH   = 8;
  localparam int unsigned CYCLE_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_CMP = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WAIT_WR  = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base_c;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [DIM_WIDTH-1:0]  dim_n;
    logic [DIM_WIDTH-1:0]  dim_k;
    logic [DIM_WIDTH-1:0]  dim_m;
    logic [ADDR_WIDTH-1:0] stride_c_n;
    logic [ADDR_WIDTH-1:0] stride_c_m;
    logic [ADDR_WIDTH-1:0] stride_b_n;
    logic [ADDR_WIDTH-1:0] stride_b_k;
    logic [ADDR_WIDTH-1:0] stride_a_k;
    logic [ADDR_WIDTH-1:0] stride_a_m;
  } gemm_job_t;

  function automatic logic has_zero_dim(input gemm_job_t job);
    return (job.dim_m == DIM_WIDTH'(0)) || (job.dim_k == DIM_WIDTH'(0)) ||
           (job.dim_n == DIM_WIDTH'(0));
  endfunction

endpackage

// File: rtl/snax_gemm_seq_ptr.sv
// Two-level stride pointer: walks an inner dimension by adds and keeps the
// start of the current outer row so it can restart or advance to the next row.
module snax_gemm_seq_ptr #(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [AddrWidth-1:0] base,
  input  logic                 inner_step,
  input  logic [AddrWidth-1:0] inner_stride,
  input  logic                 outer_step,
  input  logic [AddrWidth-1:0] outer_stride,
  input  logic                 restart,
  output logic [AddrWidth-1:0] ptr
);

  logic [AddrWidth-1:0] ptr_r;
  logic [AddrWidth-1:0] row_r;
  logic [AddrWidth-1:0] row_next_s;

  assign row_next_s = row_r + outer_stride;

  // Priority: reload base, then next row, then inner step, then row restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {AddrWidth{1'b0}};
      row_r <= {AddrWidth{1'b0}};
    end else if (load) begin
      ptr_r <= base;
      row_r <= base;
    end else if (outer_step) begin
      ptr_r <= row_next_s;
      row_r <= row_next_s;
    end else if (inner_step) begin
      ptr_r <= ptr_r + inner_stride;
    end else if (restart) begin
      ptr_r <= row_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/snax_gemm_seq.sv
// GEMM tile sequencer: walks m (outer), n, k (inner) over a latched job
// descriptor, issuing A/B fetch commands per k-step and one C writeback per tile.
module snax_gemm_seq
  import snax_gemm_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter int unsigned DimWidth  = DIM_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [3*AddrWidth-1:0] cfg_base_i,
  input  logic [3*DimWidth-1:0]  cfg_dim_i,
  input  logic [6*AddrWidth-1:0] cfg_stride_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [AddrWidth-1:0]   rd_addr_a_o,
  output logic [AddrWidth-1:0]   rd_addr_b_o,
  output logic                   rd_first_o,
  output logic                   rd_last_o,
  input  logic                   cmp_valid_i,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i,
  output logic [AddrWidth-1:0]   wr_addr_o,
  input  logic                   wr_done_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            cycles_o
);

  seq_state_e             state_r, state_nxt_s;
  gemm_job_t              job_r, cfg_job_s;
  logic [DimWidth-1:0]    m_r, n_r, k_r;
  logic [CYCLE_WIDTH-1:0] cycles_r;
  logic                   accept_s, k_step_s, tile_step_s;
  logic                   last_m_s, last_n_s, last_k_s;
  logic                   next_row_s, next_col_s, fetch_s;

  assign cfg_job_s = {cfg_base_i, cfg_dim_i, cfg_stride_i};

  assign last_m_s = (m_r == job_r.dim_m - DimWidth'(1));
  assign last_n_s = (n_r == job_r.dim_n - DimWidth'(1));
  assign last_k_s = (k_r == job_r.dim_k - DimWidth'(1));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and loop-advance strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    k_step_s    = 1'b0;
    tile_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          accept_s    = 1'b1;
          state_nxt_s = has_zero_dim(cfg_job_s) ? ST_DONE : ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (rd_ready_i) begin
          state_nxt_s = ST_WAIT_CMP;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WAIT_CMP: begin
        if (cmp_valid_i) begin
          if (last_k_s) begin
            state_nxt_s = ST_WRITE;
          end else begin
            k_step_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_WAIT_CMP;
        end
      end
      ST_WRITE: begin
        if (wr_ready_i) begin
          state_nxt_s = ST_WAIT_WR;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_WAIT_WR: begin
        if (wr_done_i) begin
          if (last_m_s && last_n_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            tile_step_s = 1'b1;
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_WAIT_WR;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Descriptor latch, loop counters and saturating busy-cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      job_r    <= {$bits(gemm_job_t){1'b0}};
      m_r      <= {DimWidth{1'b0}};
      n_r      <= {DimWidth{1'b0}};
      k_r      <= {DimWidth{1'b0}};
      cycles_r <= {CYCLE_WIDTH{1'b0}};
    end else if (accept_s) begin
      job_r    <= cfg_job_s;
      m_r      <= {DimWidth{1'b0}};
      n_r      <= {DimWidth{1'b0}};
      k_r      <= {DimWidth{1'b0}};
      cycles_r <= {CYCLE_WIDTH{1'b0}};
    end else begin
      if ((state_r != ST_IDLE) && (cycles_r != {CYCLE_WIDTH{1'b1}})) begin
        cycles_r <= cycles_r + CYCLE_WIDTH'(1);
      end
      if (k_step_s) begin
        k_r <= k_r + DimWidth'(1);
      end else if (tile_step_s) begin
        k_r <= {DimWidth{1'b0}};
        if (last_n_s) begin
          n_r <= {DimWidth{1'b0}};
          m_r <= m_r + DimWidth'(1);
        end else begin
          n_r <= n_r + DimWidth'(1);
        end
      end
    end
  end

  // A row restarts on each new n and advances by A_m on each new m;
  // B walks n rows and reloads its base on each new m; C steps n then m.
  assign next_row_s = tile_step_s & last_n_s;
  assign next_col_s = tile_step_s & ~last_n_s;

  snax_gemm_seq_ptr #(.AddrWidth(AddrWidth)) u_ptr_a (
    .clk          (clk_i),
    .rst          (rst_i),
    .load         (accept_s),
    .base         (accept_s ? cfg_job_s.base_a : job_r.base_a),
    .inner_step   (k_step_s),
    .inner_stride (job_r.stride_a_k),
    .outer_step   (next_row_s),
    .outer_stride (job_r.stride_a_m),
    .restart      (next_col_s),
    .ptr          (rd_addr_a_o)
  );

  snax_gemm_seq_ptr #(.AddrWidth(AddrWidth)) u_ptr_b (
    .clk          (clk_i),
    .rst          (rst_i),
    .load         (accept_s | next_row_s),
    .base         (accept_s ? cfg_job_s.base_b : job_r.base_b),
    .inner_step   (k_step_s),
    .inner_stride (job_r.stride_b_k),
    .outer_step   (next_col_s),
    .outer_stride (job_r.stride_b_n),
    .restart      (1'b0),
    .ptr          (rd_addr_b_o)
  );

  snax_gemm_seq_ptr #(.AddrWidth(AddrWidth)) u_ptr_c (
    .clk          (clk_i),
    .rst          (rst_i),
    .load         (accept_s),
    .base         (accept_s ? cfg_job_s.base_c : job_r.base_c),
    .inner_step   (next_col_s),
    .inner_stride (job_r.stride_c_n),
    .outer_step   (next_row_s),
    .outer_stride (job_r.stride_c_m),
    .restart      (1'b0),
    .ptr          (wr_addr_o)
  );

  assign fetch_s     = (state_r == ST_FETCH);
  assign cfg_ready_o = (state_r == ST_IDLE);
  assign busy_o      = (state_r != ST_IDLE);
  assign done_o      = (state_r == ST_DONE);
  assign wr_valid_o  = (state_r == ST_WRITE);
  assign rd_valid_o  = fetch_s;
  assign rd_first_o  = fetch_s && (k_r == DimWidth'(0));
  assign rd_last_o   = fetch_s && last_k_s;
  assign cycles_o    = cycles_r;

endmodule

// File: tb/tb_snax_gemm_seq.sv
// Directed self-checking bench for snax_gemm_seq: a small environment model
// answers fetch/writeback commands and expected addresses come from m,n,k products.
module tb_snax_gemm_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid, cfg_ready;
  logic [95:0]  cfg_base;
  logic [23:0]  cfg_dim;
  logic [191:0] cfg_stride;
  logic         rd_valid, rd_ready, rd_first, rd_last;
  logic [31:0]  rd_addr_a, rd_addr_b;
  logic         cmp_valid;
  logic         wr_valid, wr_ready, wr_done;
  logic [31:0]  wr_addr;
  logic         busy, done;
  logic [31:0]  cycles;

  int checks = 0;
  int failures = 0;

  logic [31:0] fa_q[$];
  logic [31:0] fb_q[$];
  bit          ff_q[$];
  bit          fl_q[$];
  logic [31:0] wa_q[$];
  int          accepted, done_cnt, done_at, wrdone_at, unstable, flag_viol;
  int          rd_valid_cyc, wr_valid_cyc, timed_out;
  logic [31:0] final_cycles;
  logic [31:0] single_cycles;

  always #5 clk = ~clk;

  snax_gemm_seq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_base_i   (cfg_base),
    .cfg_dim_i    (cfg_dim),
    .cfg_stride_i (cfg_stride),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .rd_addr_a_o  (rd_addr_a),
    .rd_addr_b_o  (rd_addr_b),
    .rd_first_o   (rd_first),
    .rd_last_o    (rd_last),
    .cmp_valid_i  (cmp_valid),
    .wr_valid_o   (wr_valid),
    .wr_ready_i   (wr_ready),
    .wr_addr_o    (wr_addr),
    .wr_done_i    (wr_done),
    .busy_o       (busy),
    .done_o       (done),
    .cycles_o     (cycles)
  );

  // Environment: accepts a job, answers commands with 2-cycle completion pulses,
  // optionally stalls the first fetch and injects spurious strobes.
  task automatic run_job(input logic [95:0] base, input logic [23:0] dim,
                         input logic [191:0] stride, input int stall, input bit spurious);
    logic [31:0] pa, pb;
    bit pend;
    int stall_left, cmp_wait, wr_wait;
    fa_q.delete(); fb_q.delete(); ff_q.delete(); fl_q.delete(); wa_q.delete();
    done_cnt = 0; done_at = -1; wrdone_at = -1; unstable = 0; flag_viol = 0;
    rd_valid_cyc = 0; wr_valid_cyc = 0; timed_out = 0;
    cmp_wait = 0; wr_wait = 0; pend = 1'b0; stall_left = stall; pa = 32'h0; pb = 32'h0;
    cfg_base = base; cfg_dim = dim; cfg_stride = stride; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    accepted = int'(busy);
    for (int i = 0; i < 3000 && busy; i++) begin
      cmp_valid = 1'b0; wr_done = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0; cfg_valid = 1'b0;
      if (done) begin done_cnt++; done_at = i + 1; end
      if (!rd_valid && (rd_first || rd_last)) flag_viol++;
      if (cmp_wait > 0) begin
        cmp_wait--;
        if (cmp_wait == 0) cmp_valid = 1'b1;
      end
      if (wr_wait > 0) begin
        wr_wait--;
        if (wr_wait == 0) begin wr_done = 1'b1; wrdone_at = i + 1; end
      end
      if (rd_valid) begin
        rd_valid_cyc++;
        if (pend && (rd_addr_a !== pa || rd_addr_b !== pb)) unstable++;
        if (stall_left > 0) begin
          stall_left--; pend = 1'b1; pa = rd_addr_a; pb = rd_addr_b;
        end else begin
          rd_ready = 1'b1; pend = 1'b0; cmp_wait = 2;
          fa_q.push_back(rd_addr_a); fb_q.push_back(rd_addr_b);
          ff_q.push_back(rd_first);  fl_q.push_back(rd_last);
          if (spurious) begin
            cmp_valid = 1'b1; wr_done = 1'b1; cfg_valid = 1'b1;
            cfg_base = {3{32'hdead_beef}}; cfg_dim = {3{8'd1}}; cfg_stride = {6{32'h4}};
          end
        end
      end else begin
        pend = 1'b0;
      end
      if (wr_valid) begin
        wr_valid_cyc++; wr_ready = 1'b1; wr_wait = 2; wa_q.push_back(wr_addr);
        if (spurious) cmp_valid = 1'b1;
      end
      @(negedge clk);
    end
    cmp_valid = 1'b0; wr_done = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0; cfg_valid = 1'b0;
    if (busy) timed_out = 1;
    final_cycles = cycles;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b rdv=%b wrv=%b, required 1 0 0 0 0",
               cfg_ready, busy, done, rd_valid, wr_valid);
    end
    checks++;
    if (cycles !== 32'h0 || rd_addr_a !== 32'h0 || rd_addr_b !== 32'h0 || wr_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: cycles=%h a=%h b=%h c=%h, required all 0", cycles, rd_addr_a, rd_addr_b, wr_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b ready=%b, required 0 1", busy, cfg_ready);
    end
  endtask

  task automatic test_single();
    run_job({32'h300, 32'h200, 32'h100}, {8'd1, 8'd1, 8'd1}, {6{32'h10}}, 0, 1'b0);
    single_cycles = final_cycles;
    checks++;
    if (accepted !== 1 || timed_out !== 0) begin
      failures++; $display("FAIL single_run: accepted=%0d timeout=%0d, required 1 0", accepted, timed_out);
    end
    checks++;
    if (fa_q.size() != 1 || wa_q.size() != 1) begin
      failures++; $display("FAIL single_counts: fetches=%0d writes=%0d, required 1 1", fa_q.size(), wa_q.size());
    end else begin
      checks++;
      if (fa_q[0] !== 32'h100 || fb_q[0] !== 32'h200 || ff_q[0] !== 1'b1 || fl_q[0] !== 1'b1) begin
        failures++;
        $display("FAIL single_fetch: a=%h b=%h first=%b last=%b, required 100 200 1 1", fa_q[0], fb_q[0], ff_q[0], fl_q[0]);
      end
      checks++;
      if (wa_q[0] !== 32'h300) begin
        failures++; $display("FAIL single_write: c=%h, required 300", wa_q[0]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_at !== wrdone_at + 1) begin
      failures++;
      $display("FAIL single_done: pulses=%0d at=%0d, required 1 at %0d", done_cnt, done_at, wrdone_at + 1);
    end
    checks++;
    if (final_cycles !== 32'd7 || flag_viol !== 0) begin
      failures++; $display("FAIL single_cycles: cycles=%0d flagviol=%0d, required 7 0", final_cycles, flag_viol);
    end
  endtask

  task automatic test_multi_tile(input bit spurious);
    int idx;
    logic [31:0] ea, eb;
    run_job({32'h3000, 32'h2000, 32'h1000}, {8'd2, 8'd3, 8'd2},
            {32'h8, 32'h80, 32'h8, 32'h40, 32'h8, 32'h40}, 0, spurious);
    checks++;
    if (accepted !== 1 || timed_out !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL multi_run(sp=%0d): accepted=%0d timeout=%0d done=%0d, required 1 0 1",
               spurious, accepted, timed_out, done_cnt);
    end
    checks++;
    if (fa_q.size() != 12 || wa_q.size() != 4) begin
      failures++;
      $display("FAIL multi_counts(sp=%0d): fetches=%0d writes=%0d, required 12 4", spurious, fa_q.size(), wa_q.size());
    end else begin
      idx = 0;
      for (int m = 0; m < 2; m++) begin
        for (int n = 0; n < 2; n++) begin
          for (int k = 0; k < 3; k++) begin
            ea = 32'h1000 + 32'(m) * 32'h40 + 32'(k) * 32'h8;
            eb = 32'h2000 + 32'(k) * 32'h40 + 32'(n) * 32'h8;
            checks++;
            if (fa_q[idx] !== ea || fb_q[idx] !== eb || ff_q[idx] !== (k == 0) || fl_q[idx] !== (k == 2)) begin
              failures++;
              $display("FAIL multi_fetch(sp=%0d,#%0d): a=%h b=%h f=%b l=%b, required %h %h %b %b",
                       spurious, idx, fa_q[idx], fb_q[idx], ff_q[idx], fl_q[idx], ea, eb, k == 0, k == 2);
            end
            idx++;
          end
          checks++;
          if (wa_q[m*2+n] !== 32'h3000 + 32'(m) * 32'h80 + 32'(n) * 32'h8) begin
            failures++;
            $display("FAIL multi_write(sp=%0d,m=%0d,n=%0d): c=%h, required %h", spurious, m, n,
                     wa_q[m*2+n], 32'h3000 + 32'(m) * 32'h80 + 32'(n) * 32'h8);
          end
        end
      end
    end
    checks++;
    if (final_cycles !== 32'd49 || flag_viol !== 0) begin
      failures++;
      $display("FAIL multi_cycles(sp=%0d): cycles=%0d flagviol=%0d, required 49 0", spurious, final_cycles, flag_viol);
    end
  endtask

  task automatic test_stall();
    run_job({32'h300, 32'h200, 32'h100}, {8'd1, 8'd1, 8'd1}, {6{32'h10}}, 5, 1'b0);
    checks++;
    if (unstable !== 0 || rd_valid_cyc !== 6 || timed_out !== 0) begin
      failures++;
      $display("FAIL stall_hold: unstable=%0d rdvalid_cycles=%0d timeout=%0d, required 0 6 0",
               unstable, rd_valid_cyc, timed_out);
    end
    checks++;
    if (fa_q.size() != 1 || fa_q[0] !== 32'h100 || fb_q[0] !== 32'h200) begin
      failures++; $display("FAIL stall_fetch: count=%0d, required one fetch of 100/200", fa_q.size());
    end
    checks++;
    if (final_cycles !== single_cycles + 32'd5 || final_cycles !== 32'd12) begin
      failures++;
      $display("FAIL stall_cycles: cycles=%0d, required %0d (12)", final_cycles, single_cycles + 32'd5);
    end
  endtask

  task automatic test_zero_dim();
    run_job({32'h300, 32'h200, 32'h100}, {8'd2, 8'd0, 8'd2}, {6{32'h10}}, 0, 1'b0);
    checks++;
    if (rd_valid_cyc !== 0 || wr_valid_cyc !== 0) begin
      failures++; $display("FAIL zero_cmds: rd=%0d wr=%0d, required 0 0", rd_valid_cyc, wr_valid_cyc);
    end
    checks++;
    if (accepted !== 1 || done_cnt !== 1 || done_at !== 1) begin
      failures++;
      $display("FAIL zero_done: accepted=%0d pulses=%0d at=%0d, required 1 1 1", accepted, done_cnt, done_at);
    end
    checks++;
    if (final_cycles !== 32'd1) begin
      failures++; $display("FAIL zero_cycles: cycles=%0d, required 1", final_cycles);
    end
  endtask

  task automatic test_reset_mid();
    cfg_base = {32'h3000, 32'h2000, 32'h1000}; cfg_dim = {8'd2, 8'd2, 8'd2};
    cfg_stride = {6{32'h10}}; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || wr_valid !== 1'b0) begin
      failures++; $display("FAIL mid_state: busy=%b rdv=%b wrv=%b, required 1 0 0", busy, rd_valid, wr_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || wr_valid !== 1'b0 ||
        rd_first !== 1'b0 || rd_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_ctrl: ready=%b busy=%b done=%b rdv=%b wrv=%b, required 1 0 0 0 0",
               cfg_ready, busy, done, rd_valid, wr_valid);
    end
    checks++;
    if (cycles !== 32'h0 || rd_addr_a !== 32'h0 || rd_addr_b !== 32'h0 || wr_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_data: cycles=%h a=%h b=%h c=%h, required all 0", cycles, rd_addr_a, rd_addr_b, wr_addr);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL mid_no_done: done=%b busy=%b, required 0 0", done, busy);
      end
    end
    #1 rst = 1'b0;
    run_job({32'h300, 32'h200, 32'h100}, {8'd1, 8'd1, 8'd1}, {6{32'h10}}, 0, 1'b0);
    checks++;
    if (accepted !== 1 || done_cnt !== 1 || final_cycles !== 32'd7 || timed_out !== 0) begin
      failures++;
      $display("FAIL post_reset_job: accepted=%0d done=%0d cycles=%0d, required 1 1 7", accepted, done_cnt, final_cycles);
    end
    checks++;
    if (fa_q.size() != 1 || fa_q[0] !== 32'h100 || fb_q[0] !== 32'h200 || wa_q.size() != 1 || wa_q[0] !== 32'h300) begin
      failures++; $display("FAIL post_reset_addr: fetches=%0d writes=%0d, required 100/200 -> 300", fa_q.size(), wa_q.size());
    end
  endtask

  task automatic test_spurious();
    logic [31:0] prev;
    prev = cycles;
    cmp_valid = 1'b1; wr_done = 1'b1; rd_ready = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    cmp_valid = 1'b0; wr_done = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || cycles !== prev) begin
      failures++;
      $display("FAIL idle_spurious: busy=%b ready=%b cycles=%0d, required 0 1 %0d", busy, cfg_ready, cycles, prev);
    end
    test_multi_tile(1'b1);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_base = 96'h0; cfg_dim = 24'h0; cfg_stride = 192'h0;
    rd_ready = 1'b0; cmp_valid = 1'b0; wr_ready = 1'b0; wr_done = 1'b0;
    test_reset();
    test_single();
    test_multi_tile(1'b0);
    test_stall();
    test_zero_dim();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
